sd_bmp_loader: RTL and testbench

Successor to the single-format SD photo reader. Cycles through PHOTO_NUM BMP images stored at fixed SD sector addresses, with a programmable delay between images. Parses the BMP header for pixel-data offset and bit depth, and unpacks 24 bpp or 32 bpp pixels. Writes RGB565 or RGB888 words to the DDR write port. Sits between the SD read controller and the DDR write FIFO.

---
 rtl/sd_bmp_pkg.sv | 38 +++
 rtl/sd_bmp_pix_unpack.sv | 56 +++++
 rtl/sd_bmp_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_sd_bmp_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_bmp_pkg.sv
// sd_bmp_pkg: shared constants, FSM state types and pixel packing for sd_bmp_loader.
//   - BMP header word indices (16-bit SD words, first file byte in [15:8])
//   - header size, accepted bit depths, largest accepted pixel-data offset
//   - sector FSM and pixel FSM state enums
//   - rgb888_to_565(): {R,G,B} 24 b -> RGB565
package sd_bmp_pkg;

    localparam int unsigned WORD_IDX_W = 17;

    localparam logic [WORD_IDX_W-1:0] W_OFF_LO   = 17'd5;
    localparam logic [WORD_IDX_W-1:0] W_OFF_HI   = 17'd6;
    localparam logic [WORD_IDX_W-1:0] W_BPP      = 17'd14;
    localparam logic [WORD_IDX_W-1:0] W_HDR_LAST = 17'd26;

    localparam logic [31:0] BMP_HEAD_BYTES = 32'd54;
    localparam logic [31:0] BMP_OFF_MAX    = 32'd131070;

    localparam logic [7:0] BPP_24 = 8'd24;
    localparam logic [7:0] BPP_32 = 8'd32;

    typedef enum logic [1:0] {
        S_START,
        S_READ,
        S_DELAY
    } sec_state_e;

    typedef enum logic [1:0] {
        P_HDR,
        P_SKIP,
        P_PIX,
        P_WAIT
    } pix_state_e;

    function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

endpackage

// File: rtl/sd_bmp_pix_unpack.sv
// sd_bmp_pix_unpack: turns the BMP pixel word stream into 24 b {R,G,B} pixels.
//   24 bpp: three words carry two pixels; 32 bpp: two words carry one pixel (alpha dropped).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clr          synchronous clear of the phase counter (drops any partial pixel)
//   word_en      word valid
//   word         SD word, first file byte in [15:8]
//   bpp32        1 = 32 bpp, 0 = 24 bpp
//   pix_valid    combinational: the current word completes a pixel
//   pix          completed pixel {R,G,B}
module sd_bmp_pix_unpack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        word_en,
    input  logic [15:0] word,
    input  logic        bpp32,
    output logic        pix_valid,
    output logic [23:0] pix
);

    logic [1:0]  phase_q;
    logic [15:0] w0_q;
    logic [15:0] w1_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            phase_q <= 2'd0;
            w0_q    <= 16'd0;
            w1_q    <= 16'd0;
        end else if (word_en) begin
            unique case (phase_q)
                2'd0: begin
                    w0_q    <= word;
                    phase_q <= 2'd1;
                end
                2'd1: begin
                    w1_q    <= word;
                    phase_q <= bpp32 ? 2'd0 : 2'd2;
                end
                default: phase_q <= 2'd0;
            endcase
        end
    end

    // Pixel A (and the only 32 bpp pixel) finishes on the second word, pixel B on the third.
    always_comb begin
        pix_valid = word_en && ((phase_q == 2'd1) || ((phase_q == 2'd2) && !bpp32));
        if (phase_q == 2'd2) begin
            pix = {word[7:0], word[15:8], w1_q[7:0]};
        end else begin
            pix = {word[15:8], w0_q[7:0], w0_q[15:8]};
        end
    end

endmodule

// File: rtl/sd_bmp_loader.sv
// sd_bmp_loader: cycles through PHOTO_NUM BMP images on SD, parses each header and streams
// the pixels as RGB565 (OUT_FMT=0) or RGB888 (OUT_FMT=1) words to the DDR write port.
// Optional build macro: SD_BMP_HOLD_EN adds input photo_hold; while high, the same image
// is reloaded instead of advancing photo_idx.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   ddr_max_addr      pixels to write per image
//   sd_sec_num        sectors per image (>= 1)
//   rd_busy           SD read controller busy
//   sd_rd_val_en      SD word valid
//   sd_rd_val_data    SD word, first file byte in [15:8]
//   rd_start_en       one-cycle sector read request
//   rd_sec_addr       sector address of the request
//   ddr_wr_en         pixel valid pulse
//   ddr_wr_data       pixel (OUT_W bits)
//   photo_idx         image currently loading
//   frame_done        one-cycle pulse when the last sector of an image completes
//   hdr_err           header of the current image is not usable
module sd_bmp_loader
    import sd_bmp_pkg::*;
#(
    parameter int unsigned  PHOTO_NUM         = 2,
    parameter logic [31:0]  PHOTO_ADDR_BASE   = 32'd16640,
    parameter logic [31:0]  PHOTO_ADDR_STRIDE = 32'd4672,
    parameter int unsigned  DELAY_CYC         = 50_000_000,
    parameter int unsigned  OUT_FMT           = 0,
    localparam int unsigned OUT_W             = (OUT_FMT == 0) ? 16 : 24
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SD_BMP_HOLD_EN
    input  logic             photo_hold,
`endif
    input  logic [23:0]      ddr_max_addr,
    input  logic [15:0]      sd_sec_num,
    input  logic             rd_busy,
    input  logic             sd_rd_val_en,
    input  logic [15:0]      sd_rd_val_data,
    output logic             rd_start_en,
    output logic [31:0]      rd_sec_addr,
    output logic             ddr_wr_en,
    output logic [OUT_W-1:0] ddr_wr_data,
    output logic [3:0]       photo_idx,
    output logic             frame_done,
    output logic             hdr_err
);

    localparam logic [3:0]  IDX_LAST   = 4'(PHOTO_NUM - 1);
    // DELAY_CYC=0 still spends one cycle in S_DELAY.
    localparam logic [31:0] DELAY_LOAD = (DELAY_CYC == 0) ? 32'd0 : 32'(DELAY_CYC - 1);

    // ------------------------------------------------------------------ sector FSM
    sec_state_e  sec_state;
    logic [15:0] sec_cnt;
    logic [31:0] delay_cnt;
    logic        busy_d0;
    logic        busy_d1;
    logic        busy_fall;
    logic        advance;
    logic [31:0] img_base;
    logic [3:0]  next_idx;

    assign busy_fall = busy_d1 && !busy_d0;
    assign img_base  = PHOTO_ADDR_BASE + 32'(photo_idx) * PHOTO_ADDR_STRIDE;
    assign next_idx  = (photo_idx == IDX_LAST) ? 4'd0 : photo_idx + 4'd1;

`ifdef SD_BMP_HOLD_EN
    assign advance = !photo_hold;
`else
    assign advance = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sec_state   <= S_START;
            sec_cnt     <= 16'd0;
            delay_cnt   <= 32'd0;
            busy_d0     <= 1'b0;
            busy_d1     <= 1'b0;
            rd_start_en <= 1'b0;
            rd_sec_addr <= 32'd0;
            frame_done  <= 1'b0;
            photo_idx   <= 4'd0;
        end else begin
            busy_d0     <= rd_busy;
            busy_d1     <= busy_d0;
            rd_start_en <= 1'b0;
            frame_done  <= 1'b0;
            case (sec_state)
                S_START: begin
                    rd_start_en <= 1'b1;
                    rd_sec_addr <= img_base;
                    sec_cnt     <= 16'd0;
                    sec_state   <= S_READ;
                end
                S_READ: begin
                    if (busy_fall) begin
                        rd_sec_addr <= rd_sec_addr + 32'd1;
                        if (sec_cnt == sd_sec_num - 16'd1) begin
                            frame_done <= 1'b1;
                            delay_cnt  <= DELAY_LOAD;
                            sec_state  <= S_DELAY;
                        end else begin
                            sec_cnt     <= sec_cnt + 16'd1;
                            rd_start_en <= 1'b1;
                        end
                    end
                end
                S_DELAY: begin
                    if (delay_cnt == 32'd0) begin
                        if (advance) begin
                            photo_idx <= next_idx;
                        end
                        sec_state <= S_START;
                    end else begin
                        delay_cnt <= delay_cnt - 32'd1;
                    end
                end
                default: sec_state <= S_START;
            endcase
        end
    end

    // ------------------------------------------------------------------ pixel FSM
    pix_state_e            pix_state;
    logic [WORD_IDX_W-1:0] word_cnt;
    logic [23:0]           pix_cnt;
    logic [15:0]           hdr_w5;
    logic [15:0]           hdr_w6;
    logic [7:0]            hdr_bpp;
    logic [31:0]           hdr_off;
    logic                  hdr_bad;
    logic                  unp_en;
    logic                  unp_valid;
    logic [23:0]           unp_pix;
    logic [OUT_W-1:0]      pix_fmt;

    // bfOffBits is little-endian across words 5 and 6.
    assign hdr_off = {hdr_w6[7:0], hdr_w6[15:8], hdr_w5[7:0], hdr_w5[15:8]};
    assign hdr_bad = (hdr_off < BMP_HEAD_BYTES) || hdr_off[0] || (hdr_off > BMP_OFF_MAX) ||
                     ((hdr_bpp != BPP_24) && (hdr_bpp != BPP_32));
    assign unp_en  = sd_rd_val_en && (pix_state == P_PIX) && !frame_done;

    sd_bmp_pix_unpack u_unpack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (frame_done),
        .word_en   (unp_en),
        .word      (sd_rd_val_data),
        .bpp32     (hdr_bpp == BPP_32),
        .pix_valid (unp_valid),
        .pix       (unp_pix)
    );

    if (OUT_FMT == 0) begin : g_rgb565
        assign pix_fmt = rgb888_to_565(unp_pix);
    end else begin : g_rgb888
        assign pix_fmt = unp_pix;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_state   <= P_HDR;
            word_cnt    <= '0;
            pix_cnt     <= 24'd0;
            hdr_w5      <= 16'd0;
            hdr_w6      <= 16'd0;
            hdr_bpp     <= 8'd0;
            hdr_err     <= 1'b0;
            ddr_wr_en   <= 1'b0;
            ddr_wr_data <= '0;
        end else begin
            ddr_wr_en <= 1'b0;
            // End of image (normal or short file) restarts header parsing.
            if (frame_done) begin
                pix_state <= P_HDR;
                word_cnt  <= '0;
                pix_cnt   <= 24'd0;
                hdr_err   <= 1'b0;
            end else begin
                case (pix_state)
                    P_HDR: begin
                        if (sd_rd_val_en) begin
                            word_cnt <= word_cnt + 17'd1;
                            if (word_cnt == W_OFF_LO) hdr_w5  <= sd_rd_val_data;
                            if (word_cnt == W_OFF_HI) hdr_w6  <= sd_rd_val_data;
                            if (word_cnt == W_BPP)    hdr_bpp <= sd_rd_val_data[15:8];
                            if (word_cnt == W_HDR_LAST) begin
                                if (hdr_bad) begin
                                    hdr_err   <= 1'b1;
                                    pix_state <= P_WAIT;
                                end else if (ddr_max_addr == 24'd0) begin
                                    pix_state <= P_WAIT;
                                end else if (hdr_off == BMP_HEAD_BYTES) begin
                                    pix_state <= P_PIX;
                                end else begin
                                    pix_state <= P_SKIP;
                                end
                            end
                        end
                    end
                    P_SKIP: begin
                        // The word at index offset/2 is the first pixel word.
                        if (sd_rd_val_en) begin
                            word_cnt <= word_cnt + 17'd1;
                            if (word_cnt + 17'd1 == hdr_off[WORD_IDX_W:1]) begin
                                pix_state <= P_PIX;
                            end
                        end
                    end
                    P_PIX: begin
                        if (unp_valid) begin
                            ddr_wr_en   <= 1'b1;
                            ddr_wr_data <= pix_fmt;
                            pix_cnt     <= pix_cnt + 24'd1;
                            if (pix_cnt + 24'd1 == ddr_max_addr) begin
                                pix_state <= P_WAIT;
                            end
                        end
                    end
                    P_WAIT: ;
                    default: pix_state <= P_HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_bmp_loader.sv
// Self-checking bench for sd_bmp_loader (PHOTO_NUM=3, DELAY_CYC=10, RGB565 output).
// Acts as the SD read controller: each image is a random byte file with a crafted BMP
// header; expected pixels are derived directly from the file bytes.
module tb_sd_bmp_loader;

    localparam int unsigned NUM    = 3;
    localparam int unsigned DLY    = 10;
    localparam logic [31:0] BASE   = 32'd16640;
    localparam logic [31:0] STRIDE = 32'd4672;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] ddr_max_addr;
    logic [15:0] sd_sec_num;
    logic        rd_busy;
    logic        sd_rd_val_en;
    logic [15:0] sd_rd_val_data;
    logic        rd_start_en;
    logic [31:0] rd_sec_addr;
    logic        ddr_wr_en;
    logic [15:0] ddr_wr_data;
    logic [3:0]  photo_idx;
    logic        frame_done;
    logic        hdr_err;
`ifdef SD_BMP_HOLD_EN
    logic        photo_hold = 1'b0;
`endif

    always #5 clk = ~clk;

    sd_bmp_loader #(
        .PHOTO_NUM (NUM),
        .DELAY_CYC (DLY),
        .OUT_FMT   (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef SD_BMP_HOLD_EN
        .photo_hold     (photo_hold),
`endif
        .ddr_max_addr   (ddr_max_addr),
        .sd_sec_num     (sd_sec_num),
        .rd_busy        (rd_busy),
        .sd_rd_val_en   (sd_rd_val_en),
        .sd_rd_val_data (sd_rd_val_data),
        .rd_start_en    (rd_start_en),
        .rd_sec_addr    (rd_sec_addr),
        .ddr_wr_en      (ddr_wr_en),
        .ddr_wr_data    (ddr_wr_data),
        .photo_idx      (photo_idx),
        .frame_done     (frame_done),
        .hdr_err        (hdr_err)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_pix[$];
    int          n_wr     = 0;
    int          fd_cnt   = 0;
    longint      cyc      = 0;
    longint      fd_cyc   = 0;
    bit          have_fd  = 0;
    int          img_idx  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    function automatic logic [15:0] to565(input int r, input int g, input int b);
        return 16'(((r >> 3) << 11) | ((g >> 2) << 5) | (b >> 3));
    endfunction

    always @(posedge clk) cyc++;

    // Write / frame monitor.
    always @(negedge clk) begin
        if (rst_n && ddr_wr_en) begin
            n_wr++;
            if (exp_pix.size() > 0) check("pixel", 32'(ddr_wr_data), 32'(exp_pix.pop_front()));
        end
        if (rst_n && frame_done) fd_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_start_en) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, 32'(rd_start_en), 0);
        check({tag, "_addr"},  rd_sec_addr, 0);
        check({tag, "_wr_en"}, 32'(ddr_wr_en), 0);
        check({tag, "_wdata"}, 32'(ddr_wr_data), 0);
        check({tag, "_idx"},   32'(photo_idx), 0);
        check({tag, "_fdone"}, 32'(frame_done), 0);
        check({tag, "_herr"},  32'(hdr_err), 0);
    endtask

    // One image: build the file, derive expectations, serve sector reads.
    task automatic run_image(input int bpp, input int off, input int max_px,
                             input int wps, input int nsec, input bit do_reset);
        byte unsigned fb[];
        int           nwords;
        int           n_exp;
        int           wr0;
        int           fd0;
        int           idx;
        bit           exp_err;
        bit           ok;

        nwords = wps * nsec;
        fb = new[nwords * 2];
        foreach (fb[i]) fb[i] = 8'($urandom);
        fb[10] = 8'(off);
        fb[11] = 8'(off >> 8);
        fb[12] = 8'(off >> 16);
        fb[13] = 8'(off >> 24);
        fb[28] = 8'(bpp);
        fb[29] = 8'd0;

        exp_err = (nwords >= 27) &&
                  (off < 54 || (off % 2) != 0 || off > 131070 || !(bpp == 24 || bpp == 32));
        exp_pix.delete();
        n_exp = 0;
        if (!exp_err && !do_reset && nwords >= 27) begin
            for (int i = 0; i < max_px; i++) begin
                int r_pos;
                r_pos = off + i * (bpp / 8) + 2;  // byte order B, G, R
                if (r_pos / 2 >= nwords) break;
                exp_pix.push_back(to565(fb[r_pos], fb[r_pos-1], fb[r_pos-2]));
                n_exp++;
            end
        end

        sd_sec_num   = 16'(nsec);
        ddr_max_addr = 24'(max_px);
        wr0 = n_wr;
        fd0 = fd_cnt;

        for (int s = 0; s < nsec; s++) begin
            wait_start(ok);
            if (!ok) begin
                check("start_seen", 32'(rd_start_en), 1);
                finish_sim();
            end
            if (s == 0) begin
                if (have_fd) check("delay_gap", 32'(cyc - fd_cyc), DLY + 1);
                check("photo_idx", 32'(photo_idx), 32'(img_idx));
                check("hdr_err_clear", 32'(hdr_err), 0);
            end
            check("sec_addr", rd_sec_addr, BASE + 32'(img_idx) * STRIDE + 32'(s));
            repeat (2) @(negedge clk);
            rd_busy = 1'b1;
            for (int w = 0; w < wps; w++) begin
                idx = s * wps + w;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                sd_rd_val_en   = 1'b1;
                sd_rd_val_data = {fb[2*idx], fb[2*idx+1]};
                @(negedge clk);
                sd_rd_val_en = 1'b0;
                if (do_reset && w == 9) begin
                    rd_busy = 1'b0;
                    rst_n   = 1'b0;
                    @(negedge clk);
                    check_all_zero("midreset");
                    rst_n   = 1'b1;
                    img_idx = 0;
                    have_fd = 0;
                    exp_pix.delete();
                    return;
                end
            end
            @(negedge clk);
            rd_busy = 1'b0;
        end

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        check("frame_done", 32'(frame_done), 1);
        check("hdr_err", 32'(hdr_err), 32'(exp_err));
        fd_cyc  = cyc;
        have_fd = 1;
        @(negedge clk);
        check("writes", 32'(n_wr - wr0), 32'(n_exp));
        check("frame_cnt", 32'(fd_cnt - fd0), 1);
        img_idx = (img_idx + 1) % NUM;
    endtask

    initial begin
        int bpp;
        int off;
        int mx;
        int wps;
        int need;

        rst_n          = 1'b0;
        ddr_max_addr   = 24'd0;
        sd_sec_num     = 16'd1;
        rd_busy        = 1'b0;
        sd_rd_val_en   = 1'b0;
        sd_rd_val_data = 16'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        run_image(24, 54, 4, 17, 2, 0);       // 4 pixels right after the header
        run_image(32, 138, 3, 40, 2, 0);      // pixel data after a gap, alpha dropped
        run_image(16, 54, 4, 20, 2, 0);       // unsupported depth
        run_image(24, 54, 2, 14, 2, 0);       // short file: one pixel word only
        run_image(24, 60, 0, 20, 3, 0);       // no pixels requested
        run_image(24, 55, 4, 20, 2, 0);       // odd offset
        run_image(32, 131072, 4, 30, 1, 0);   // offset too large
        for (int k = 0; k < 5; k++) begin
            bpp  = ($urandom_range(0, 1) == 0) ? 24 : 32;
            off  = 54 + 2 * $urandom_range(0, 20);
            mx   = $urandom_range(1, 12);
            wps  = $urandom_range(16, 48);
            need = (off + mx * (bpp / 8) + 1) / 2 + 1;
            run_image(bpp, off, mx, wps, $urandom_range(1, need / wps + 2), 0);
        end
        run_image(24, 54, 4, 30, 2, 1);       // reset during the first sector
        run_image(32, 54, 5, 20, 3, 0);       // restart from image 0
        run_image(24, 58, 6, 25, 2, 0);
        finish_sim();
    end

endmodule
